// File: rtl/pipeline_skid_reg_if.sv
// Handshake and data bundle for pipeline_skid_reg: upstream push side, downstream pop side
// and the occupancy count. master = surrounding logic, slave = the register block.
interface pipeline_skid_reg_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int LANES      = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [ADDR_WIDTH-1:0]       addr_in;
    logic [LANES*INST_WIDTH-1:0] inst_in;
    logic [LANES-1:0]            mask_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [ADDR_WIDTH-1:0]       addr_out;
    logic [LANES*INST_WIDTH-1:0] inst_out;
    logic [LANES-1:0]            mask_out;
    logic [1:0]                  count;

    modport master (
        output in_valid, addr_in, inst_in, mask_in, out_ready,
        input  in_ready, out_valid, addr_out, inst_out, mask_out, count
    );

    modport slave (
        input  in_valid, addr_in, inst_in, mask_in, out_ready,
        output in_ready, out_valid, addr_out, inst_out, mask_out, count
    );
endinterface

// File: rtl/pipeline_skid_reg.sv
// Fetch-entry pipeline register. Default build: single register with combinational in_ready.
// Define PIPELINE_SKID_REG_SKID_EN for a main+skid pair with a registered in_ready.
module pipeline_skid_reg #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int LANES      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipeline_skid_reg_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t                      state, state_nxt;
    logic                        out_valid, in_ready;
    logic                        push, pop, store;
    logic                        load_main_in;
    logic [ADDR_WIDTH-1:0]       main_addr;
    logic [LANES*INST_WIDTH-1:0] main_inst;
    logic [LANES-1:0]            main_mask;

    assign out_valid = (state != EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;
    // An all-lanes-invalid entry still completes the handshake but is never stored.
    assign store     = push & (|bus.mask_in) & ~flush;

`ifdef PIPELINE_SKID_REG_SKID_EN
    logic                        load_skid, load_main_skid;
    logic [ADDR_WIDTH-1:0]       skid_addr;
    logic [LANES*INST_WIDTH-1:0] skid_inst;
    logic [LANES-1:0]            skid_mask;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        load_main_in = 1'b0;
`ifdef PIPELINE_SKID_REG_SKID_EN
        load_skid      = 1'b0;
        load_main_skid = 1'b0;
`endif
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (store) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (store && pop) begin
                        load_main_in = 1'b1;
`ifdef PIPELINE_SKID_REG_SKID_EN
                    end else if (store) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
`endif
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
`ifdef PIPELINE_SKID_REG_SKID_EN
                    // in_ready is low here, so a pop is the only way out.
                    if (pop) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
`else
                    state_nxt = EMPTY;
`endif
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_addr <= '0;
            main_inst <= '0;
            main_mask <= '0;
        end else if (load_main_in) begin
            main_addr <= bus.addr_in;
            main_inst <= bus.inst_in;
            main_mask <= bus.mask_in;
`ifdef PIPELINE_SKID_REG_SKID_EN
        end else if (load_main_skid) begin
            main_addr <= skid_addr;
            main_inst <= skid_inst;
            main_mask <= skid_mask;
`endif
        end
    end

`ifdef PIPELINE_SKID_REG_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_addr <= '0;
            skid_inst <= '0;
            skid_mask <= '0;
        end else if (load_skid) begin
            skid_addr <= bus.addr_in;
            skid_inst <= bus.inst_in;
            skid_mask <= bus.mask_in;
        end
    end

    // Registered ready breaks the out_ready -> in_ready timing path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready <= 1'b1;
        else      in_ready <= (state_nxt != FULL);
    end
`else
    assign in_ready = ~out_valid | bus.out_ready;
`endif

    // Bubbles are presented as zero so inst_out reads as a NOP.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.addr_out  = out_valid ? main_addr : '0;
    assign bus.inst_out  = out_valid ? main_inst : '0;
    assign bus.mask_out  = out_valid ? main_mask : '0;
    assign bus.count     = state;
endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed bench for pipeline_skid_reg (LANES=2); steps that need two held entries
// are enabled when PIPELINE_SKID_REG_SKID_EN is defined.
module tb_pipeline_skid_reg;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int L  = 2;

    logic clk, rst, flush;
    int   tests, fails;

    pipeline_skid_reg_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .LANES(L)) bus ();

    pipeline_skid_reg #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .LANES(L)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a,
                         input logic [L*IW-1:0] i, input logic [L-1:0] m);
        bus.in_valid = v;
        bus.addr_in  = a;
        bus.inst_in  = i;
        bus.mask_in  = m;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b0;
        #12;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_addr_out", 64'(bus.addr_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // first push into empty block
        drive(1'b1, 32'h00400000, {32'h0, 32'h24080001}, 2'b01);
        #1 check("push0_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("push0_out_valid", 64'(bus.out_valid), 64'd1);
        check("push0_addr", 64'(bus.addr_out), 64'h00400000);
        check("push0_inst", 64'(bus.inst_out), {32'h0, 32'h24080001});
        check("push0_mask", 64'(bus.mask_out), 64'd1);
        check("push0_count", 64'(bus.count), 64'd1);
        step();
        check("hold_addr", 64'(bus.addr_out), 64'h00400000);
        check("hold_count", 64'(bus.count), 64'd1);

`ifdef PIPELINE_SKID_REG_SKID_EN
        drive(1'b1, 32'h00400004, {32'h0, 32'h24090002}, 2'b01);
        step();
        bus.in_valid = 1'b0;
        check("fill_count", 64'(bus.count), 64'd2);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_head", 64'(bus.addr_out), 64'h00400000);
        bus.out_ready = 1'b1;
        step();
        check("pop1_addr", 64'(bus.addr_out), 64'h00400004);
        check("pop1_count", 64'(bus.count), 64'd1);
        check("pop1_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("pop2_count", 64'(bus.count), 64'd0);
        check("pop2_out_valid", 64'(bus.out_valid), 64'd0);
        check("pop2_addr", 64'(bus.addr_out), 64'd0);
`else
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1 check("comb_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("pop_count", 64'(bus.count), 64'd0);
        check("pop_out_valid", 64'(bus.out_valid), 64'd0);
`endif

        // back-to-back streaming: each cycle pops the previous entry and pushes the next
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00400100 + 32'(4 * i), {32'(i), 32'h24080000 + 32'(i)}, 2'b01);
            step();
            check($sformatf("strm%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("strm%0d_addr", i), 64'(bus.addr_out), 64'(32'h00400100 + 32'(4 * i)));
            check($sformatf("strm%0d_count", i), 64'(bus.count), 64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("strm_drain_count", 64'(bus.count), 64'd0);

        bus.out_ready = 1'b0;
`ifdef PIPELINE_SKID_REG_SKID_EN
        // flush from FULL with an upstream entry waiting
        drive(1'b1, 32'h00400000, {32'h0, 32'h24080001}, 2'b01);
        step();
        drive(1'b1, 32'h00400004, {32'h0, 32'h24090002}, 2'b01);
        step();
        check("fl_full_count", 64'(bus.count), 64'd2);
        drive(1'b1, 32'h00400008, {32'h0, 32'h240a0003}, 2'b01);
        flush = 1'b1;
        #1 check("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_full_count0", 64'(bus.count), 64'd0);
        check("fl_full_valid", 64'(bus.out_valid), 64'd0);
        check("fl_full_inst", 64'(bus.inst_out), 64'd0);
        check("fl_full_rdy_after", 64'(bus.in_ready), 64'd1);
        step();
        check("fl_full_no8", 64'(bus.out_valid), 64'd0);
`endif
        // flush with a simultaneous push and pop
        drive(1'b1, 32'h00400000, {32'h0, 32'h24080001}, 2'b01);
        step();
        check("fl_one_count", 64'(bus.count), 64'd1);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00400008, {32'h0, 32'h240a0003}, 2'b01);
        flush = 1'b1;
        #1 check("fl_one_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("fl_one_count0", 64'(bus.count), 64'd0);
        check("fl_one_valid", 64'(bus.out_valid), 64'd0);
        check("fl_one_addr", 64'(bus.addr_out), 64'd0);
        step();
        check("fl_one_no8", 64'(bus.out_valid), 64'd0);

        // zero-mask push is accepted but dropped
        drive(1'b1, 32'h00400010, {32'h33333333, 32'h44444444}, 2'b00);
        #1 check("m0_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("m0_count", 64'(bus.count), 64'd0);
        check("m0_valid", 64'(bus.out_valid), 64'd0);
        drive(1'b1, 32'h00400014, {32'h11111111, 32'h22222222}, 2'b10);
        step();
        bus.in_valid = 1'b0;
        check("m2_mask", 64'(bus.mask_out), 64'd2);
        check("m2_inst", 64'(bus.inst_out), {32'h11111111, 32'h22222222});
        check("m2_count", 64'(bus.count), 64'd1);

`ifdef PIPELINE_SKID_REG_SKID_EN
        drive(1'b1, 32'h00400018, {32'h0, 32'h240b0004}, 2'b01);
        step();
        bus.in_valid = 1'b0;
        check("mr_count2", 64'(bus.count), 64'd2);
`endif
        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        check("mr_count", 64'(bus.count), 64'd0);
        check("mr_valid", 64'(bus.out_valid), 64'd0);
        check("mr_addr", 64'(bus.addr_out), 64'd0);
        check("mr_inst", 64'(bus.inst_out), 64'd0);
        check("mr_mask", 64'(bus.mask_out), 64'd0);
        check("mr_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("mr_rel_in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h00400020, {32'h0, 32'h24080020}, 2'b01);
        step();
        bus.in_valid = 1'b0;
        check("mr_push_valid", 64'(bus.out_valid), 64'd1);
        check("mr_push_addr", 64'(bus.addr_out), 64'h00400020);
        check("mr_push_count", 64'(bus.count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
